// File: rtl/sqg_pkg.sv
// Shared types and defaults for the sqg box-buffer drain path.
package sqg_pkg;

    localparam int unsigned SQG_AW = 6;
    localparam int unsigned SQG_DW = 8;

    typedef logic [1:0] box_idx_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        SUM   = 2'd2,
        FLUSH = 2'd3
    } sqg_state_e;

endpackage

// File: rtl/sqg_bc_ram.sv
// 2^AW x DW box-buffer RAM: one synchronous write port, one synchronous read port
// (1-cycle latency). Read data holds while no read is issued; the array has no reset.
module sqg_bc_ram import sqg_pkg::*; #(
    parameter int unsigned AW = SQG_AW,
    parameter int unsigned DW = SQG_DW
) (
    input  logic          CLK,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = mem_q[rd_addr_i];
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sqg_drain.sv
// Captures one 64-byte box frame and streams it out over valid/ready once address 63 is
// written. Optional trailing checksum beat when SQG_DRAIN_CHECKSUM_EN is defined.
module sqg_drain import sqg_pkg::*; #(
    parameter int unsigned BOX_IDX = 0,
    parameter int unsigned AW      = SQG_AW,
    parameter int unsigned DW      = SQG_DW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wen_sqg,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          overflow,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [1:0]    out_box
);

    localparam logic [AW-1:0] LastAddr = {AW{1'b1}};

    sqg_state_e    state_q, state_d;
    logic [AW-1:0] rp_q, rp_d;
    logic          issued_all_q, issued_all_d;
    logic          rd_vld_q, rd_vld_d;
    logic          rd_last_q, rd_last_d;
    logic          skid_vld_q, skid_vld_d;
    logic [DW-1:0] skid_data_q, skid_data_d;
    logic          skid_last_q, skid_last_d;
    logic          overflow_q, overflow_d;

    logic          ram_we;
    logic          ram_re;
    logic [DW-1:0] ram_rdata;
    logic          beat_valid;
    logic [DW-1:0] beat_data;
    logic          beat_last63;
    logic          beat_take;

    sqg_bc_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .CLK       (CLK),
        .wr_en_i   (ram_we),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (ram_re),
        .rd_addr_i (rp_q),
        .rd_data_o (ram_rdata)
    );

    // The RAM read register is the output stage; the skid holds the older beat when a
    // read was already in flight as the consumer stalled.
    always_comb begin
        beat_valid  = skid_vld_q | rd_vld_q;
        beat_data   = skid_vld_q ? skid_data_q : ram_rdata;
        beat_last63 = skid_vld_q ? skid_last_q : rd_last_q;
        beat_take   = beat_valid && out_ready && (state_q == DRAIN);
        ram_we      = wen_sqg && (state_q == FILL);
        ram_re      = (state_q == DRAIN) && !issued_all_q && !skid_vld_q;
    end

    always_comb begin
        rp_d         = rp_q;
        issued_all_d = 1'b0;
        rd_last_d    = rd_last_q;
        if (ram_re) begin
            rp_d      = rp_q + 1'b1;
            rd_last_d = (rp_q == LastAddr);
        end
        if (state_q == DRAIN) begin
            issued_all_d = issued_all_q || (ram_re && (rp_q == LastAddr));
        end

        if (ram_re) begin
            rd_vld_d = 1'b1;
        end else begin
            rd_vld_d = rd_vld_q && !(beat_take && !skid_vld_q);
        end

        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        if (skid_vld_q) begin
            if (out_ready) begin
                skid_vld_d = 1'b0;
            end
        end else if (rd_vld_q && !out_ready && ram_re) begin
            skid_vld_d  = 1'b1;
            skid_data_d = ram_rdata;
            skid_last_d = rd_last_q;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        unique case (state_q)
            FILL: begin
                busy = 1'b0;
                if (wen_sqg && (wr_addr == LastAddr)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (beat_take && beat_last63) begin
`ifdef SQG_DRAIN_CHECKSUM_EN
                    state_d = SUM;
`else
                    state_d = FILL;
`endif
                end
            end
            SUM: begin
`ifdef SQG_DRAIN_CHECKSUM_EN
                if (out_ready) begin
                    state_d = FILL;
                end
`else
                state_d = FILL;
`endif
            end
            FLUSH: begin
                state_d = FILL;
            end
        endcase
        overflow_d = overflow_q | (wen_sqg & busy);
    end

`ifdef SQG_DRAIN_CHECKSUM_EN
    logic [DW-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (state_q == FILL) begin
            sum_d = '0;
        end else if (beat_take) begin
            sum_d = sum_q + beat_data;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    always_comb begin
        out_valid = beat_valid || (state_q == SUM);
        out_data  = '0;
        out_last  = 1'b0;
        if (state_q == SUM) begin
            out_data = sum_q;
            out_last = 1'b1;
        end else if (beat_valid) begin
            out_data = beat_data;
        end
    end
`else
    always_comb begin
        out_valid = beat_valid;
        out_data  = beat_valid ? beat_data : '0;
        out_last  = beat_valid & beat_last63;
    end
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= FILL;
            rp_q         <= '0;
            issued_all_q <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            skid_vld_q   <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rp_q         <= rp_d;
            issued_all_q <= issued_all_d;
            rd_vld_q     <= rd_vld_d;
            rd_last_q    <= rd_last_d;
            skid_vld_q   <= skid_vld_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            overflow_q   <= overflow_d;
        end
    end

    assign overflow = overflow_q;
    assign out_box  = box_idx_t'(BOX_IDX);

endmodule

// File: tb/tb_sqg_drain.sv
// Scoreboard bench for sqg_drain: frames push expected beats, a negedge monitor pops
// and compares every accepted beat and checks stall stability.
module tb_sqg_drain;
    import sqg_pkg::*;

    localparam int unsigned BoxIdx = 2;
`ifdef SQG_DRAIN_CHECKSUM_EN
    localparam int FrameBeats = 65;
`else
    localparam int FrameBeats = 64;
`endif
    localparam int BusyCycles = FrameBeats + 1;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       wen_sqg = 1'b0;
    logic [5:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       out_ready = 1'b0;
    logic       busy, overflow, out_valid, out_last;
    logic [7:0] out_data;
    logic [1:0] out_box;

    sqg_drain #(
        .BOX_IDX (BoxIdx),
        .AW      (6),
        .DW      (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .wen_sqg   (wen_sqg),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .overflow  (overflow),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_box   (out_box)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    int         checks = 0;
    int         failures = 0;
    beat_t      exp_q[$];
    logic [7:0] img [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        wen_sqg = 1'b1;
        wr_addr = a;
        wr_data = d;
        img[a]  = d;
        tick();
        wen_sqg = 1'b0;
    endtask

    task automatic push_frame();
        logic [7:0] sum;
        sum = '0;
        for (int i = 0; i < 64; i++) begin
            sum += img[i];
`ifdef SQG_DRAIN_CHECKSUM_EN
            exp_q.push_back('{data: img[i], last: 1'b0});
`else
            exp_q.push_back('{data: img[i], last: (i == 63)});
`endif
        end
`ifdef SQG_DRAIN_CHECKSUM_EN
        exp_q.push_back('{data: sum, last: 1'b1});
`endif
    endtask

    // Starts in the cycle the address-63 write is driven; returns in the cycle busy falls.
    task automatic frame(input logic [7:0] d63, input bit toggle, input int ovf_at,
                         input string tag);
        int first_valid;
        int busy_cnt;
        bit done;
        img[63] = d63;
        push_frame();
        wen_sqg = 1'b1;
        wr_addr = 6'd63;
        wr_data = d63;
        tick();
        wen_sqg = 1'b0;
        first_valid = -1;
        busy_cnt = 0;
        done = 1'b0;
        for (int k = 1; k < 400 && !done; k++) begin
            if (out_valid && first_valid < 0) first_valid = k;
            if (!busy) begin
                done = 1'b1;
            end else begin
                busy_cnt++;
                wen_sqg = (k == ovf_at);
                wr_addr = 6'd10;
                wr_data = 8'd99;
                out_ready = toggle ? ~out_ready : 1'b1;
                tick();
                wen_sqg = 1'b0;
            end
        end
        out_ready = 1'b1;
        check({tag, "_done"}, done, 1);
        check({tag, "_first_valid"}, first_valid, 2);
        if (!toggle) check({tag, "_busy_cycles"}, busy_cnt, BusyCycles);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    logic [7:0] prev_data;
    logic       prev_last;
    bit         prev_stall = 1'b0;

    always @(negedge CLK) begin
        beat_t e;
        if (!RST) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", out_data, e.data);
                    check("beat_last", out_last, e.last);
                    check("beat_box", out_box, BoxIdx);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        int idle_bad;
        for (int i = 0; i < 64; i++) img[i] = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_box", out_box, BoxIdx);
        RST = 1'b1;
        out_ready = 1'b1;
        tick();

        // Constant 16 everywhere; checksum 16*64 mod 256 = 0.
        for (int i = 0; i < 63; i++) wr(6'(i), 8'd16);
        frame(8'd16, 1'b0, -1, "const16");

        // data = 2*addr, consumer alternating ready.
        for (int i = 0; i < 63; i++) wr(6'(i), 8'(2 * i));
        frame(8'd126, 1'b1, -1, "ramp_toggle");

        // Sparse frame: only address 5 and 63 rewritten.
        wr(6'd5, 8'd30);
        frame(8'd16, 1'b0, -1, "sparse");
        check("sparse_img5", img[5], 30);

        // Write during DRAIN is dropped and flags overflow.
        frame(8'd126, 1'b0, 5, "ovf");
        check("ovf_set", overflow, 1);
        frame(8'd126, 1'b0, -1, "ovf_next");
        check("ovf_sticky", overflow, 1);

        // Reset at beat 20 of a drain.
        img[63] = 8'd55;
        push_frame();
        wen_sqg = 1'b1;
        wr_addr = 6'd63;
        wr_data = 8'd55;
        tick();
        wen_sqg = 1'b0;
        out_ready = 1'b1;
        repeat (21) tick();
        check("rst_mid_valid_before", out_valid, 1);
        check("rst_mid_data_before", out_data, img[20]);
        RST = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_overflow", overflow, 0);
        exp_q.delete();
        tick();
        RST = 1'b1;
        idle_bad = 0;
        repeat (80) begin
            tick();
            if (out_valid || busy) idle_bad++;
        end
        check("rst_idle", idle_bad, 0);

        // Back-to-back: second address-63 write lands in the cycle busy falls.
        frame(8'd200, 1'b0, -1, "b2b_a");
        frame(8'd7, 1'b0, -1, "b2b_b");
        check("b2b_no_overflow", overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
